exception_ctrl: RTL and testbench

//  Exception/ERET sequencer at the MEM stage; the sole writer of the CP0 register file.

---
 rtl/exception_ctrl.sv | 151 +++++++++++++++
 tb/tb_exception_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// Exception/ERET sequencer at the MEM stage and the only writer of CP0.
// It writes EPC, Cause and Status one per cycle, then flushes and redirects fetch.
//
//  state   | meaning
//  --------+---------------------------------------------------
//  IDLE    | no sequence in progress; watching MEM for requests
//  W_EPC   | writing EPC (reg 14) with the faulting PC
//  W_CAUSE | writing Cause (reg 13) with BD and ExcCode
//  W_STAT  | writing Status (reg 12) with EXL set
//  E_STAT  | ERET: writing Status (reg 12) with EXL cleared
//  REDIR   | one-cycle flush, new_pc = vector or EPC
module exception_ctrl #(
   parameter logic [31:0] VEC_OFFSET = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_bd,
   input  logic        mem_syscall,
   input  logic        mem_eret,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_ebase,
   input  logic [31:0] cp0_epc,
   output logic        cp0_we,
   output logic [4:0]  cp0_waddr,
   output logic [31:0] cp0_wdata,
   output logic        stall,
   output logic        flush,
   output logic [31:0] new_pc
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_EPC   = 3'd1,
      W_CAUSE = 3'd2,
      W_STAT  = 3'd3,
      E_STAT  = 3'd4,
      REDIR   = 3'd5
   } state_t;

   localparam logic [4:0] EXC_INT   = 5'd0;
   localparam logic [4:0] EXC_SYS   = 5'd8;
   localparam logic [4:0] ADDR_STAT = 5'd12;
   localparam logic [4:0] ADDR_CAUS = 5'd13;
   localparam logic [4:0] ADDR_EPC  = 5'd14;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        bd_q;
   logic [4:0]  exc_q;
   logic        eret_q;
   logic        we_q;
   logic [4:0]  waddr_q;
   logic        flush_q;

   logic int_pend;
   logic take_int;
   logic take_eret;
   logic accept;
   logic unused_cause;

   // EXL masks interrupts, which also stops a nested interrupt from clobbering EPC.
   assign int_pend  = cp0_status[0] & ~cp0_status[1]
                    & (|(cp0_cause[15:10] & cp0_status[15:10]));
   assign take_int  = int_pend;
   assign take_eret = ~int_pend & ~mem_syscall & mem_eret;

   // Gated by rst so stall drops immediately while reset is held.
   assign accept = rst & (state_q == IDLE) & mem_valid
                 & (int_pend | mem_syscall | mem_eret);

   assign unused_cause = ^{cp0_cause[31], cp0_cause[6:2]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         bd_q    <= 1'b0;
         exc_q   <= '0;
         eret_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         flush_q <= 1'b0;
      end else begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         flush_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  pc_q   <= mem_pc;
                  bd_q   <= mem_bd;
                  exc_q  <= take_int ? EXC_INT : EXC_SYS;
                  eret_q <= take_eret;
                  we_q   <= 1'b1;
                  if (take_eret) begin
                     state_q <= E_STAT;
                     waddr_q <= ADDR_STAT;
                  end else begin
                     state_q <= W_EPC;
                     waddr_q <= ADDR_EPC;
                  end
               end
            end
            W_EPC: begin
               state_q <= W_CAUSE;
               we_q    <= 1'b1;
               waddr_q <= ADDR_CAUS;
            end
            W_CAUSE: begin
               state_q <= W_STAT;
               we_q    <= 1'b1;
               waddr_q <= ADDR_STAT;
            end
            W_STAT, E_STAT: begin
               state_q <= REDIR;
               flush_q <= 1'b1;
            end
            REDIR:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Status, Cause and the redirect bases are taken live so CP0 updates made
   // earlier in the sequence (notably EPC) are already reflected.
   always_comb begin
      cp0_wdata = '0;
      case (state_q)
         W_EPC:   cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
         W_CAUSE: cp0_wdata = {bd_q, cp0_cause[30:7], exc_q, cp0_cause[1:0]};
         W_STAT:  cp0_wdata = cp0_status | 32'h0000_0002;
         E_STAT:  cp0_wdata = cp0_status & ~32'h0000_0002;
         default: cp0_wdata = '0;
      endcase
   end

   always_comb begin
      new_pc = '0;
      if (state_q == REDIR)
         new_pc = eret_q ? cp0_epc : (cp0_ebase + VEC_OFFSET);
   end

   assign cp0_we    = we_q;
   assign cp0_waddr = waddr_q;
   assign flush     = flush_q;
   assign stall     = (state_q != IDLE) | accept;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: syscall, BD slot, interrupt priority,
// ERET, EXL masking, mem_valid gating and async reset mid-sequence.
module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_bd;
   logic        mem_syscall;
   logic        mem_eret;
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;
   logic [31:0] cp0_ebase;
   logic [31:0] cp0_epc;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic        stall;
   logic        flush;
   logic [31:0] new_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exception_ctrl #(.VEC_OFFSET(32'h0000_0180)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_valid   (mem_valid),
      .mem_pc      (mem_pc),
      .mem_bd      (mem_bd),
      .mem_syscall (mem_syscall),
      .mem_eret    (mem_eret),
      .cp0_status  (cp0_status),
      .cp0_cause   (cp0_cause),
      .cp0_ebase   (cp0_ebase),
      .cp0_epc     (cp0_epc),
      .cp0_we      (cp0_we),
      .cp0_waddr   (cp0_waddr),
      .cp0_wdata   (cp0_wdata),
      .stall       (stall),
      .flush       (flush),
      .new_pc      (new_pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      mem_valid   = 1'b0;
      mem_syscall = 1'b0;
      mem_eret    = 1'b0;
      mem_bd      = 1'b0;
   endtask

   // Call in the accept cycle; walks W_EPC, W_CAUSE, W_STAT, REDIR, IDLE.
   task automatic exc_seq(input string tag, input logic [31:0] e_epc, input logic [31:0] e_cause,
                          input logic [31:0] e_stat, input logic [31:0] e_pc);
      tick(); clear_req(); #1;
      chk({tag, " epc we"},    32'(cp0_we),    32'd1);
      chk({tag, " epc addr"},  32'(cp0_waddr), 32'd14);
      chk({tag, " epc data"},  cp0_wdata,      e_epc);
      chk({tag, " epc stall"}, 32'(stall),     32'd1);
      tick(); #1;
      chk({tag, " cause addr"}, 32'(cp0_waddr), 32'd13);
      chk({tag, " cause data"}, cp0_wdata,      e_cause);
      tick(); #1;
      chk({tag, " stat addr"},  32'(cp0_waddr), 32'd12);
      chk({tag, " stat data"},  cp0_wdata,      e_stat);
      chk({tag, " stat flush"}, 32'(flush),     32'd0);
      tick(); #1;
      chk({tag, " redir flush"}, 32'(flush),  32'd1);
      chk({tag, " redir we"},    32'(cp0_we), 32'd0);
      chk({tag, " redir pc"},    new_pc,      e_pc);
      tick(); #1;
      chk({tag, " idle flush"}, 32'(flush), 32'd0);
      chk({tag, " idle stall"}, 32'(stall), 32'd0);
   endtask

   task automatic eret_seq(input string tag, input logic [31:0] e_stat, input logic [31:0] e_pc);
      tick(); clear_req(); #1;
      chk({tag, " estat we"},   32'(cp0_we),    32'd1);
      chk({tag, " estat addr"}, 32'(cp0_waddr), 32'd12);
      chk({tag, " estat data"}, cp0_wdata,      e_stat);
      tick(); #1;
      chk({tag, " redir flush"}, 32'(flush), 32'd1);
      chk({tag, " redir pc"},    new_pc,     e_pc);
      tick(); #1;
      chk({tag, " idle flush"}, 32'(flush), 32'd0);
      chk({tag, " idle stall"}, 32'(stall), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      clear_req();
      mem_pc     = '0;
      cp0_status = '0;
      cp0_cause  = '0;
      cp0_ebase  = '0;
      cp0_epc    = '0;
      #12;
      chk("rst we",    32'(cp0_we), 32'd0);
      chk("rst stall", 32'(stall),  32'd0);
      chk("rst flush", 32'(flush),  32'd0);
      chk("rst newpc", new_pc,      32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // syscall, not in delay slot
      mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h0000_1000; #1;
      chk("t1 acc stall", 32'(stall),  32'd1);
      chk("t1 acc we",    32'(cp0_we), 32'd0);
      exc_seq("t1", 32'h0000_1000, 32'h0000_0020, 32'h0000_0002, 32'h0000_0180);

      // syscall in delay slot
      mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h0000_2004; mem_bd = 1'b1; #1;
      chk("t2 acc stall", 32'(stall), 32'd1);
      exc_seq("t2", 32'h0000_2000, 32'h8000_0020, 32'h0000_0002, 32'h0000_0180);

      // interrupt beats syscall
      cp0_status = 32'h0000_1001; cp0_cause = 32'h0000_1000; cp0_ebase = 32'h8000_0000;
      mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h0000_4000; #1;
      chk("t3 acc stall", 32'(stall), 32'd1);
      exc_seq("t3", 32'h0000_4000, 32'h0000_1000, 32'h0000_1003, 32'h8000_0180);

      // interrupt still pending but mem_valid=0
      chk("novalid stall", 32'(stall), 32'd0);
      tick();
      chk("novalid we",    32'(cp0_we), 32'd0);

      // eret
      cp0_status = 32'h0000_1003; cp0_cause = 32'h0000_0000; cp0_epc = 32'h0000_3000;
      mem_valid = 1'b1; mem_eret = 1'b1; #1;
      chk("t4 acc stall", 32'(stall), 32'd1);
      eret_seq("t4", 32'h0000_1001, 32'h0000_3000);

      // EXL masks a pending interrupt
      cp0_status = 32'h0000_1003; cp0_cause = 32'h0000_1000;
      mem_valid = 1'b1; mem_pc = 32'h0000_5000; #1;
      chk("t5 stall", 32'(stall), 32'd0);
      tick();
      chk("t5 we",    32'(cp0_we), 32'd0);
      chk("t5 stall2", 32'(stall), 32'd0);

      // nested syscall under EXL is still taken
      mem_syscall = 1'b1; #1;
      chk("nest acc stall", 32'(stall), 32'd1);
      exc_seq("nest", 32'h0000_5000, 32'h0000_1020, 32'h0000_1003, 32'h8000_0180);

      // async reset in W_CAUSE
      cp0_status = '0; cp0_cause = '0; cp0_ebase = '0;
      mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h0000_6000; #1;
      tick(); clear_req();
      tick(); #1;
      chk("t6 wcause we",   32'(cp0_we),    32'd1);
      chk("t6 wcause addr", 32'(cp0_waddr), 32'd13);
      mem_valid = 1'b1; mem_syscall = 1'b1;
      rst = 1'b0; #1;
      chk("t6 rst we",    32'(cp0_we), 32'd0);
      chk("t6 rst stall", 32'(stall),  32'd0);
      chk("t6 rst flush", 32'(flush),  32'd0);
      @(negedge clk);
      clear_req();
      rst = 1'b1;
      tick();
      chk("t6 post we",    32'(cp0_we), 32'd0);
      chk("t6 post flush", 32'(flush),  32'd0);
      tick();
      chk("t6 post flush2", 32'(flush), 32'd0);

      // resumes normally from IDLE
      cp0_status = 32'h0000_0003; cp0_epc = 32'h0000_7000;
      mem_valid = 1'b1; mem_eret = 1'b1; #1;
      chk("t6 resume stall", 32'(stall), 32'd1);
      eret_seq("t6r", 32'h0000_0001, 32'h0000_7000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
